// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   MULDIV_WIDTH : default operand / HI / LO width
//   OP_*         : ex_op encodings for MULT, MULTU, DIV, DIVU
//   state_t      : sequencer states IDLE, RUN, FIXUP
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Explicit encodings keep the state register values stable for existing
  // debug scripts that decode the raw bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   is_div  : 1 = restoring trial-subtract-shift, 0 = add-shift multiply
//   hi_in   : accumulator (multiply) or partial remainder (divide)
//   lo_in   : multiplier being consumed (multiply) or dividend/quotient (divide)
//   operand : multiplicand (multiply) or divisor (divide)
//   hi_out, lo_out : updated register pair after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    // Multiply: conditional add keeps its carry, which becomes the new MSB
    // when {carry, acc, multiplier} shifts right by one.
    sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);

    // Divide: the remainder can exceed WIDTH bits for one cycle after the
    // shift, so compare at WIDTH+1 bits; the difference itself always fits.
    shifted = {hi_in, lo_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, operand});
    diff    = shifted[WIDTH-1:0] - operand;

    if (is_div) begin
      hi_out = fits ? diff : shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], fits};
    end else begin
      {hi_out, lo_out} = {sum, lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
//   clk, rst_n     : core clock, synchronous active-low reset
//   ex_start/ex_op : start MULT/MULTU/DIV/DIVU with operands ex_rs, ex_rt
//   ex_mthi/mtlo   : direct HI/LO write from ex_wdata while idle
//   id_hilo_use    : ID holds a HI/LO-touching instruction
//   stall          : freeze PC and IF/ID, bubble ID/EX
//   busy           : operation in flight (registered)
//   done           : one-cycle pulse after HI/LO updated by an operation
//   hi, lo         : HI/LO registers
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_start,
  input  logic [1:0]       ex_op,
  input  logic [WIDTH-1:0] ex_rs,
  input  logic [WIDTH-1:0] ex_rt,
  input  logic             ex_mthi,
  input  logic             ex_mtlo,
  input  logic [WIDTH-1:0] ex_wdata,
  input  logic             id_hilo_use,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand;
  logic             neg_main;
  logic             neg_rem;
  logic             div_zero;

  logic             start_signed;
  logic             start_div;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;
  logic             is_div;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    start_signed = (ex_op == OP_MULT) || (ex_op == OP_DIV);
    start_div    = (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
    // Negating the most negative value yields itself, which read as unsigned
    // is exactly its magnitude.
    rs_abs = (start_signed && ex_rs[WIDTH-1]) ? -ex_rs : ex_rs;
    rt_abs = (start_signed && ex_rt[WIDTH-1]) ? -ex_rt : ex_rt;
    is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    prod_fix = neg_main ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    // Restoring division by zero naturally leaves the dividend magnitude as
    // the remainder, so only the quotient needs forcing.
    quo_fix  = div_zero ? '1 : (neg_main ? -acc_lo : acc_lo);
    rem_fix  = neg_rem ? -acc_hi : acc_hi;
  end

  assign stall = id_hilo_use & (busy | ex_start);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (is_div),
    .hi_in   (acc_hi),
    .lo_in   (acc_lo),
    .operand (operand),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= OP_MULT;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_start) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= '0;
            op_q     <= ex_op;
            acc_hi   <= '0;
            acc_lo   <= start_div ? rs_abs : rt_abs;
            operand  <= start_div ? rt_abs : rs_abs;
            neg_main <= start_signed & (ex_rs[WIDTH-1] ^ ex_rt[WIDTH-1]);
            neg_rem  <= start_signed & ex_rs[WIDTH-1];
            div_zero <= start_div & (ex_rt == '0);
          end else begin
            if (ex_mthi) hi <= ex_wdata;
            if (ex_mtlo) lo <= ex_wdata;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (count == LAST) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
